mix_columns_engine: RTL
=======================

// Module: mix_columns_engine
// PURPOSE
//  Sequential, parametrised AES column-mixing engine. Supports forward MixColumns and
//  InvMixColumns, selected per transaction, on a 128-bit state.
//  Mixes COLS_PER_CYCLE columns per clock. Uses valid/ready handshakes on input and output.
//  Sits between ShiftRows/InvShiftRows and AddRoundKey in the iterative AES128 round datapath.
// PARAMETERS
//  COLS_PER_CYCLE  1  columns mixed per clock; legal values 1, 2, 4 (else elaboration error)
// PORTS
//  clk        input   1    clock, rising edge
//  rst        input   1    asynchronous reset, active-high
//  in_valid   input   1    state_in/inv_in valid
//  in_ready   output  1    engine can accept a state this cycle
//  inv_in     input   1    0 = MixColumns {02,03,01,01}; 1 = InvMixColumns {0e,0b,0d,09}
//  state_in   input   128  input state
//  out_valid  output  1    state_out valid
//  out_ready  input   1    downstream accepts state_out
//  state_out  output  128  mixed state
// BEHAVIOUR
//  - Byte map (in and out): column c = bits [127-32c -: 32]; row r of column c = bits [127-32c-8r -: 8].
//    Byte 0 = [127:120] = row0/col0.
//  - Arithmetic: GF(2^8) mod x^8+x^4+x^3+x+1 (0x11b).
//    xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1b : 8'h00).
//    Constant multipliers are xtime/XOR networks; no generic multiplier loop.
//  - Matrices are circulant. Row r of the output column = sum over k of M[(k-r) mod 4] * s[k],
//    with M = {02,03,01,01} (forward) or {0e,0b,0d,09} (inverse).
//  - FSM: IDLE, BUSY, DONE.
//      IDLE: in_ready=1. On in_valid, latch state_in and inv_in, set col_ptr=0, go to BUSY.
//      BUSY: each cycle, mix columns col_ptr..col_ptr+COLS_PER_CYCLE-1 in place and advance col_ptr.
//            After the last group, go to DONE. in_ready=0.
//      DONE: out_valid=1, state_out stable. On out_ready, the transaction completes.
//            If in_valid is also high that cycle, accept the new state and go to BUSY; else go to IDLE.
//  - in_ready = (IDLE) | (DONE & out_ready). Back-to-back accept costs no bubble cycle.
//  - Latency: out_valid rises 4/COLS_PER_CYCLE clock edges after the accepting edge
//    (4, 2 or 1 edges). Throughput: one state per 4/COLS_PER_CYCLE + 1 cycles.
//  - Mode is latched at accept. inv_in changes during BUSY/DONE have no effect.
//  - While out_valid=1 and out_ready=0: state_out and out_valid hold indefinitely.
//  - in_valid while BUSY: ignored. Upstream must hold in_valid until in_ready.
//  - col_ptr is 2 bits and wraps to 0 when the transaction ends. It is not observable on ports.
//  - Reset (any state, including mid-BUSY): FSM=IDLE, col_ptr=0, data register=128'h0.
//    Outputs: out_valid=0, in_ready=1 (IDLE), state_out=128'h0. The in-flight transaction is dropped.
//  - state_out is a register output; no combinational path from state_in to state_out.
// CONFIGURATION
//  MIXCOL_BYPASS_EN defined:
//    - Adds port `bypass_in input 1`, latched at accept like inv_in.
//    - When latched bypass=1: BUSY lasts exactly one cycle and columns are copied unmodified.
//      state_out = state_in. Used for the final AES round.
//    - inv_in is ignored when bypass=1.
//  MIXCOL_BYPASS_EN undefined: no bypass_in port; every transaction is mixed.
// TESTING (run for COLS_PER_CYCLE = 1, 2, 4)
//  1. Forward, FIPS-197 columns:
//     state_in = db135345_f20a225c_01010101_c6c6c6c6, inv_in=0
//     -> state_out = 8e4da1bc_9fdc589d_01010101_c6c6c6c6, out_valid after 4/2/1 edges.
//  2. Inverse round-trip:
//     state_in = 8e4da1bc_9fdc589d_01010101_c6c6c6c6, inv_in=1
//     -> state_out = db135345_f20a225c_01010101_c6c6c6c6.
//     Also d4d4d4d5_2d26314c_... (inv=0) -> d5d5d7d6_4d7ebdf8_...
//  3. Backpressure: hold out_ready=0 for 10 cycles after out_valid.
//     -> state_out stable and in_ready=0 throughout.
//     Then out_ready=1 with in_valid=1 -> new state accepted on the same edge.
//  4. Reset mid-BUSY (COLS_PER_CYCLE=1, assert rst 2 cycles after accept)
//     -> out_valid=0, state_out=0, in_ready=1 immediately (asynchronous).
//     Next transaction produces a correct result.
//  5. Mode latch: toggle inv_in every cycle during BUSY
//     -> result matches the mode sampled at accept. Back-to-back stream of 8 random states
//     -> all 8 outputs match the reference model, in order.
//  6. MIXCOL_BYPASS_EN: bypass_in=1, state_in = 00112233_44556677_8899aabb_ccddeeff
//     -> identical state_out after exactly 1 edge, for any inv_in.

Source files
------------

// File: rtl/mix_columns_engine.sv
// AES MixColumns / InvMixColumns engine; mixes COLS_PER_CYCLE columns per clock.
// Ports: clk, rst (async high), in_valid/in_ready/inv_in/state_in,
//        out_valid/out_ready/state_out; bypass_in when MIXCOL_BYPASS_EN is defined.
module mix_columns_engine #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         inv_in,
  input  logic [127:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out
`ifdef MIXCOL_BYPASS_EN
  ,
  input  logic         bypass_in
`endif
);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 &&
      COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("COLS_PER_CYCLE must be 1, 2 or 4");
  end

  // STEP is 0 for four columns: the pointer wraps straight back.
  localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST = 2'(4 - COLS_PER_CYCLE);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t       state, state_nx;
  logic [127:0] data, mixed;
  logic [1:0]   col_ptr;
  logic         inv_q, byp_q;
  logic         accept, last;

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // k indexes the circulant row {02,03,01,01} or {0e,0b,0d,09}.
  function automatic logic [7:0] mulk(input logic [7:0] x,
                                      input logic [1:0] k,
                                      input logic       inv);
    logic [7:0] x2, x4, x8, r;
    x2 = xt(x);
    x4 = xt(x2);
    x8 = xt(x4);
    r  = x;
    case ({inv, k})
      3'b000:  r = x2;
      3'b001:  r = x2 ^ x;
      3'b100:  r = x8 ^ x4 ^ x2;
      3'b101:  r = x8 ^ x2 ^ x;
      3'b110:  r = x8 ^ x4 ^ x;
      3'b111:  r = x8 ^ x;
      default: r = x;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c,
                                          input logic        inv);
    logic [31:0] res;
    logic [7:0]  acc;
    res = '0;
    for (int r = 0; r < 4; r++) begin
      acc = '0;
      for (int k = 0; k < 4; k++)
        acc ^= mulk(c[31-8*k -: 8], 2'(k - r), inv);
      res[31-8*r -: 8] = acc;
    end
    return res;
  endfunction

  always_comb begin
    logic [1:0] idx;
    mixed = data;
    for (int g = 0; g < COLS_PER_CYCLE; g++) begin
      idx = col_ptr + 2'(g);
      mixed[127-32*int'(idx) -: 32] =
        mix_col(data[127-32*int'(idx) -: 32], inv_q);
    end
  end

  assign last      = byp_q | (col_ptr == LAST);
  assign accept    = in_valid & in_ready;
  assign state_out = data;

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = BUSY;
      end
      BUSY: begin
        if (last) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) state_nx = in_valid ? BUSY : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      data    <= '0;
      col_ptr <= '0;
      inv_q   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        data    <= state_in;
        inv_q   <= inv_in;
        col_ptr <= '0;
      end else if (state == BUSY) begin
        data    <= byp_q ? data : mixed;
        col_ptr <= last ? 2'd0 : col_ptr + STEP;
      end
    end
  end

`ifdef MIXCOL_BYPASS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         byp_q <= 1'b0;
    else if (accept) byp_q <= bypass_in;
  end
`else
  assign byp_q = 1'b0;
`endif

endmodule
